pulpino_word_serializer: RTL and testbench
==========================================

Name: pulpino_word_serializer

Overview:
- Parametrised successor of the single-word byte writer on the PULPino-to-host bridge.
- Buffers outgoing words in a small FIFO and serialises each word into WORD_LANES lanes of LANE_W bits.
- Uses toggle handshakes per lane and a level handshake per word.
- Adds word buffering, configurable lane order, optional input synchronisers and status outputs.

Parameters:
- LANE_W, 8: width of one output lane (bits).
- WORD_LANES, 4: lanes per word; word width = LANE_W*WORD_LANES; legal range 1..16.
- FIFO_DEPTH, 4: word entries buffered; any value >= 1, not required to be a power of 2.
- MSB_FIRST, 0: 0 sends lane 0 (bits LANE_W-1:0) first; 1 sends the top lane first.
- SYNC_STAGES, 0: flip-flop stages on did_byte_read_flicker and did_word_read_flicker before use; 0 means no stages.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_word  in  LANE_W*WORD_LANES  word to enqueue.
- in_valid  in  1  in_word is valid this cycle.
- in_ready  out  1  FIFO can accept a word; equals !full.
- enable  in  1  permits starting a new word.
- out_data  out  LANE_W  current lane presented to the reader.
- did_byte_write_flicker  out  1  byte toggle; a byte is pending while it differs from did_byte_read_flicker.
- did_word_write_flicker  out  1  word-complete level flag.
- did_byte_read_flicker  in  1  reader byte acknowledge toggle.
- did_word_read_flicker  in  1  reader word acknowledge level.
- busy  out  1  high in any state except IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of words queued.
- words_sent  out  16  count of completed words; wraps at 2^16.

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - All outputs go to 0; in_ready goes to 1.
  - FIFO is flushed, state returns to IDLE, synchroniser flops clear.
  - Reset mid-word abandons that word with no further flicker activity.
- All outputs are registered. The names brd and wrd below mean the read flickers after SYNC_STAGES.
- FIFO:
  - A push occurs when in_valid && in_ready.
  - A pop occurs only on the IDLE->SEND transition.
  - Push and pop in the same cycle: level unchanged. When full, in_ready = 0 regardless of a same-cycle pop; there is no bypass.
  - FIFO order is first-in, first-out, and the read/write pointers wrap at FIFO_DEPTH.
- States:
  - IDLE, if enable && fifo_level != 0 && wrd == 0:
    - Pop the head word into the shift register.
    - Set out_data to the first lane.
    - Set did_byte_write_flicker <= ~brd.
    - Set lane_cnt = WORD_LANES-1; go to SEND.
    - Latency from a non-empty FIFO to out_data valid is 1 cycle.
  - IDLE, otherwise: hold all outputs. out_data keeps the last lane sent.
  - SEND, byte acknowledged (brd == did_byte_write_flicker):
    - If lane_cnt != 0: present the next lane, toggle did_byte_write_flicker, decrement lane_cnt.
    - If lane_cnt == 0: set did_word_write_flicker <= 1 and go to WORDACK.
  - SEND, not acknowledged: hold.
  - WORDACK, wrd == 1: clear did_word_write_flicker, increment words_sent, go to IDLE.
  - WORDACK, wrd == 0: hold.
- Lane order: lane k is bits (k+1)*LANE_W-1 : k*LANE_W. MSB_FIRST reverses the sequence.
- WORD_LANES == 1: SEND lasts until the single lane is acknowledged, then the FSM goes to WORDACK.
- enable:
  - Sampled only in IDLE.
  - Dropping enable mid-word has no effect; the word completes.
- Reader acknowledges early or twice: a toggle only counts when the two byte flags are equal. No lane is skipped or repeated.
- Next word start: IDLE waits for wrd to return to 0 before starting the next word, giving a four-phase word handshake.

Decomposition:
- Package pulpino_bridge_pkg:
  - State enum: IDLE, SEND, WORDACK.
  - Default lane-width and lane-count constants shared with the reader-side block.
- Sub-module pulpino_word_fifo: synchronous count-based FIFO parametrised by width and depth, exposing full, empty and level.
- Synchroniser: a generate loop inside the top module. No separate module.

Test Plan:
- Reset / single word: reset, push 32'hDDCCBBAA, enable=1, reader acknowledges every byte after 3 cycles.
  - out_data sequence: AA, BB, CC, DD.
  - Byte flag toggles 4 times.
  - Word flag rises after the DD acknowledge and falls 1 cycle after wrd=1.
  - words_sent = 1.
- MSB_FIRST=1, same word -> out_data sequence DD, CC, BB, AA.
- FIFO full: FIFO_DEPTH=4, enable=0, push 5 words.
  - in_ready = 0 after the 4th push; fifo_level = 4; the 5th word is not accepted.
  - Set enable=1: words emerge in order. in_ready rises the cycle after the first pop.
- Enable and word handshake gating:
  - enable dropped after byte 2 -> word completes.
  - Next word does not start until enable=1 and wrd=0; holding wrd=1 keeps busy=0 with no byte toggles.
- Reset mid-operation: reset asserted during lane 3 -> next cycle all outputs are 0, fifo_level = 0, state is IDLE.
- Parametrised run: LANE_W=16, WORD_LANES=2, SYNC_STAGES=2, push 32'h12345678.
  - Lanes are 5678 then 1234.
  - Each acknowledge takes effect 2 cycles later than with SYNC_STAGES=0.

Source files
------------

// File: rtl/pulpino_bridge_pkg.sv
// Shared types and defaults for the PULPino-to-host bridge.
// The writer-side serializer and the reader-side block both pull lane geometry from here.
package pulpino_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WORDACK = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_LANE_W     = 8;
    localparam int unsigned DEFAULT_WORD_LANES = 4;

    // Index width for a counter that must address n items; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulpino_word_fifo.sv
// Synchronous count-based word FIFO; depth need not be a power of two.
// Pushes are dropped when full and pops are ignored when empty.
module pulpino_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    import pulpino_bridge_pkg::*;

    localparam int unsigned PTR_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pulpino_word_serializer.sv
// Buffers words and streams each one out as LANE_W-bit lanes over a toggle byte
// handshake, closing every word with a four-phase level handshake.
module pulpino_word_serializer
    import pulpino_bridge_pkg::*;
#(
    parameter int unsigned LANE_W      = DEFAULT_LANE_W,
    parameter int unsigned WORD_LANES  = DEFAULT_WORD_LANES,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [LANE_W*WORD_LANES-1:0]       in_word,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               enable,
    output logic [LANE_W-1:0]                  out_data,
    output logic                               did_byte_write_flicker,
    output logic                               did_word_write_flicker,
    input  logic                               did_byte_read_flicker,
    input  logic                               did_word_read_flicker,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [15:0]                        words_sent
);

    localparam int unsigned WORD_W = LANE_W * WORD_LANES;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LCNT_W = cnt_width(WORD_LANES);

    state_e              state_q, state_d;
    logic [LCNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [LANE_W-1:0]   out_data_q, out_data_d;
    logic                byte_flk_q, byte_flk_d;
    logic                word_flk_q, word_flk_d;
    logic [15:0]         words_sent_q, words_sent_d;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rdata;

    logic [SYNC_STAGES:0] brd_chain;
    logic [SYNC_STAGES:0] wrd_chain;
    logic                 brd;
    logic                 wrd;

    pulpino_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // With zero stages the chain collapses to a straight wire from the reader.
    assign brd_chain[0] = did_byte_read_flicker;
    assign wrd_chain[0] = did_word_read_flicker;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic brd_q, brd_d;
        logic wrd_q, wrd_d;

        always_comb begin
            brd_d = brd_chain[g];
            wrd_d = wrd_chain[g];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                brd_q <= 1'b0;
                wrd_q <= 1'b0;
            end else begin
                brd_q <= brd_d;
                wrd_q <= wrd_d;
            end
        end

        assign brd_chain[g+1] = brd_q;
        assign wrd_chain[g+1] = wrd_q;
    end

    assign brd = brd_chain[SYNC_STAGES];
    assign wrd = wrd_chain[SYNC_STAGES];

    function automatic logic [LANE_W-1:0] lead_lane(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WORD_W-1 -: LANE_W];
        end
        return w[LANE_W-1:0];
    endfunction

    // Moves the next lane into the lead position so lead_lane always reads it.
    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << LANE_W;
        end
        return w >> LANE_W;
    endfunction

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        byte_flk_d   = byte_flk_q;
        word_flk_d   = word_flk_q;
        words_sent_d = words_sent_q;
        fifo_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty && !wrd) begin
                    fifo_pop   = 1'b1;
                    out_data_d = lead_lane(fifo_rdata);
                    shift_d    = advance(fifo_rdata);
                    byte_flk_d = ~brd;
                    lane_cnt_d = LCNT_W'(WORD_LANES - 1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                // A lane is acknowledged only once the reader's toggle matches ours.
                if (brd == byte_flk_q) begin
                    if (lane_cnt_q != '0) begin
                        out_data_d = lead_lane(shift_q);
                        shift_d    = advance(shift_q);
                        byte_flk_d = ~byte_flk_q;
                        lane_cnt_d = lane_cnt_q - LCNT_W'(1);
                    end else begin
                        word_flk_d = 1'b1;
                        state_d    = WORDACK;
                    end
                end
            end
            WORDACK: begin
                if (wrd) begin
                    word_flk_d   = 1'b0;
                    words_sent_d = words_sent_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_cnt_q   <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            byte_flk_q   <= 1'b0;
            word_flk_q   <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            byte_flk_q   <= byte_flk_d;
            word_flk_q   <= word_flk_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign in_ready               = !fifo_full;
    assign out_data               = out_data_q;
    assign did_byte_write_flicker = byte_flk_q;
    assign did_word_write_flicker = word_flk_q;
    assign busy                   = (state_q != IDLE);
    assign words_sent             = words_sent_q;

endmodule

// File: tb/tb_pulpino_word_serializer.sv
// Directed bench for pulpino_word_serializer: a cycle table for one word on the
// default and MSB-first builds, then hand sequences for FIFO, gating, reset and sync.
module tb_pulpino_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_word;
    logic        in_valid;
    logic        enable;
    logic        brd;
    logic        wrd;

    logic        in_ready;
    logic [7:0]  out_data;
    logic        bwf;
    logic        wwf;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] words_sent;

    logic        m_in_ready;
    logic [7:0]  m_out_data;
    logic        m_bwf;
    logic        m_wwf;
    logic        m_busy;
    logic [2:0]  m_fifo_level;
    logic [15:0] m_words_sent;

    logic [31:0] p_in_word;
    logic        p_in_valid;
    logic        p_enable;
    logic        p_brd;
    logic        p_wrd;
    logic        p_in_ready;
    logic [15:0] p_out_data;
    logic        p_bwf;
    logic        p_wwf;
    logic        p_busy;
    logic [2:0]  p_fifo_level;
    logic [15:0] p_words_sent;

    int vectors     = 0;
    int miscompares = 0;
    int exp_sent    = 0;

    always #5 clk = ~clk;

    pulpino_word_serializer u_dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .enable(enable), .out_data(out_data),
        .did_byte_write_flicker(bwf), .did_word_write_flicker(wwf),
        .did_byte_read_flicker(brd), .did_word_read_flicker(wrd),
        .busy(busy), .fifo_level(fifo_level), .words_sent(words_sent)
    );

    pulpino_word_serializer #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
        .in_ready(m_in_ready), .enable(enable), .out_data(m_out_data),
        .did_byte_write_flicker(m_bwf), .did_word_write_flicker(m_wwf),
        .did_byte_read_flicker(brd), .did_word_read_flicker(wrd),
        .busy(m_busy), .fifo_level(m_fifo_level), .words_sent(m_words_sent)
    );

    pulpino_word_serializer #(.LANE_W(16), .WORD_LANES(2), .SYNC_STAGES(2)) u_par (
        .clk(clk), .rst_n(rst_n), .in_word(p_in_word), .in_valid(p_in_valid),
        .in_ready(p_in_ready), .enable(p_enable), .out_data(p_out_data),
        .did_byte_write_flicker(p_bwf), .did_word_write_flicker(p_wwf),
        .did_byte_read_flicker(p_brd), .did_word_read_flicker(p_wrd),
        .busy(p_busy), .fifo_level(p_fifo_level), .words_sent(p_words_sent)
    );

    typedef struct packed {
        logic        rstn;
        logic        valid;
        logic [31:0] word;
        logic        en;
        logic        b;
        logic        w;
        logic [7:0]  e_data;
        logic [7:0]  e_mdata;
        logic        e_bwf;
        logic        e_wwf;
        logic        e_busy;
        logic        e_rdy;
        logic [2:0]  e_lvl;
        logic [15:0] e_sent;
    } vec_t;

    vec_t tbl [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rstn;
        in_valid = v.valid;
        in_word  = v.word;
        enable   = v.en;
        brd      = v.b;
        wrd      = v.w;
        tick();
    endtask

    task automatic waitPending(input string name);
        int n = 0;
        while (bwf == brd && n < 50) begin
            tick();
            n++;
        end
        if (bwf == brd) timeoutFail(name);
    endtask

    // Reader model: acks each lane as soon as it is pending, checks lane order on both builds.
    task automatic readWord(input logic [31:0] w, input int drop_after, input bit hold_wrd);
        for (int k = 0; k < 4; k++) begin
            waitPending($sformatf("lane%0d_pending", k));
            checkOutput($sformatf("lane%0d_data", k), {24'd0, out_data}, {24'd0, w[k*8 +: 8]});
            checkOutput($sformatf("msb_lane%0d_data", k), {24'd0, m_out_data}, {24'd0, w[(3-k)*8 +: 8]});
            if (k + 1 == drop_after) enable = 1'b0;
            brd = bwf;
            tick();
        end
        checkOutput("word_flag_rise", {31'd0, wwf}, 32'd1);
        checkOutput("busy_in_wordack", {31'd0, busy}, 32'd1);
        wrd = 1'b1;
        tick();
        exp_sent++;
        checkOutput("word_flag_fall", {31'd0, wwf}, 32'd0);
        checkOutput("words_sent", {16'd0, words_sent}, exp_sent);
        if (!hold_wrd) wrd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] fw [5];
        logic [31:0] ga;
        logic [31:0] gb;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hAA, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hAA, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hAA, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hCC, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hCC, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hCC, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd1};
        tbl[17] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd1};
        tbl[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd1};

        fw[0] = 32'h44332211;
        fw[1] = 32'h88776655;
        fw[2] = 32'hCCBBAA99;
        fw[3] = 32'h00FFEEDD;
        fw[4] = 32'h5A5A5A5A;
        ga    = 32'hA4A3A2A1;
        gb    = 32'hB4B3B2B1;

        rst_n = 1'b0; in_word = '0; in_valid = 1'b0; enable = 1'b0; brd = 1'b0; wrd = 1'b0;
        p_in_word = '0; p_in_valid = 1'b0; p_enable = 1'b0; p_brd = 1'b0; p_wrd = 1'b0;

        $display("[TB] single word table, default and MSB-first builds");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("row%0d_out_data", i),  {24'd0, out_data},   {24'd0, tbl[i].e_data});
            checkOutput($sformatf("row%0d_msb_data", i),  {24'd0, m_out_data}, {24'd0, tbl[i].e_mdata});
            checkOutput($sformatf("row%0d_byte_flag", i), {31'd0, bwf},        {31'd0, tbl[i].e_bwf});
            checkOutput($sformatf("row%0d_word_flag", i), {31'd0, wwf},        {31'd0, tbl[i].e_wwf});
            checkOutput($sformatf("row%0d_busy", i),      {31'd0, busy},       {31'd0, tbl[i].e_busy});
            checkOutput($sformatf("row%0d_in_ready", i),  {31'd0, in_ready},   {31'd0, tbl[i].e_rdy});
            checkOutput($sformatf("row%0d_level", i),     {29'd0, fifo_level}, {29'd0, tbl[i].e_lvl});
            checkOutput($sformatf("row%0d_sent", i),      {16'd0, words_sent}, {16'd0, tbl[i].e_sent});
        end
        exp_sent = 1;
        checkOutput("msb_sent",      {16'd0, m_words_sent}, 32'd1);
        checkOutput("msb_byte_flag", {31'd0, m_bwf},        32'd0);
        checkOutput("msb_word_flag", {31'd0, m_wwf},        32'd0);
        checkOutput("msb_busy",      {31'd0, m_busy},       32'd0);
        checkOutput("msb_in_ready",  {31'd0, m_in_ready},   32'd1);
        checkOutput("msb_level",     {29'd0, m_fifo_level}, 32'd0);

        $display("[TB] FIFO full and drain order");
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_word  = fw[i];
            in_valid = 1'b1;
            tick();
            checkOutput($sformatf("fill%0d_level", i), {29'd0, fifo_level}, (i + 1 > 4) ? 32'd4 : 32'(i + 1));
            checkOutput($sformatf("fill%0d_in_ready", i), {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();
        checkOutput("first_pop_level", {29'd0, fifo_level}, 32'd3);
        checkOutput("first_pop_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) readWord(fw[i], 0, 1'b0);
        repeat (5) tick();
        checkOutput("drained_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("drained_busy", {31'd0, busy}, 32'd0);
        checkOutput("drained_byte_flag", {31'd0, bwf}, {31'd0, brd});

        $display("[TB] enable and word handshake gating");
        enable = 1'b0;
        in_valid = 1'b1; in_word = ga; tick();
        in_word = gb; tick();
        in_valid = 1'b0;
        enable = 1'b1;
        readWord(ga, 2, 1'b1);
        repeat (2) begin
            tick();
            checkOutput("gated_enable_busy", {31'd0, busy}, 32'd0);
        end
        enable = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("gated_wrd_busy", {31'd0, busy}, 32'd0);
            checkOutput("gated_wrd_byte_flag", {31'd0, bwf}, {31'd0, brd});
            checkOutput("gated_wrd_level", {29'd0, fifo_level}, 32'd1);
        end
        wrd = 1'b0;
        tick();
        checkOutput("released_busy", {31'd0, busy}, 32'd1);
        checkOutput("released_data", {24'd0, out_data}, 32'hB1);
        readWord(gb, 0, 1'b0);

        $display("[TB] reset during the last lane");
        in_valid = 1'b1; in_word = 32'h0D0C0B0A; tick();
        in_word = 32'h77665544; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            waitPending("reset_lane_pending");
            brd = bwf;
            tick();
        end
        checkOutput("pre_reset_data", {24'd0, out_data}, 32'h0D);
        rst_n = 1'b0; brd = 1'b0; wrd = 1'b0;
        tick();
        checkOutput("reset_data",      {24'd0, out_data},   32'd0);
        checkOutput("reset_msb_data",  {24'd0, m_out_data}, 32'd0);
        checkOutput("reset_byte_flag", {31'd0, bwf},        32'd0);
        checkOutput("reset_word_flag", {31'd0, wwf},        32'd0);
        checkOutput("reset_busy",      {31'd0, busy},       32'd0);
        checkOutput("reset_in_ready",  {31'd0, in_ready},   32'd1);
        checkOutput("reset_level",     {29'd0, fifo_level}, 32'd0);
        checkOutput("reset_sent",      {16'd0, words_sent}, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("post_reset_quiet_busy", {31'd0, busy}, 32'd0);
            checkOutput("post_reset_quiet_flag", {31'd0, bwf},  32'd0);
        end

        $display("[TB] 16-bit lanes with two sync stages");
        p_in_word = 32'h12345678; p_in_valid = 1'b1; p_enable = 1'b1;
        tick();
        checkOutput("par_push_level", {29'd0, p_fifo_level}, 32'd1);
        p_in_valid = 1'b0;
        tick();
        checkOutput("par_lane0",      {16'd0, p_out_data},   32'h5678);
        checkOutput("par_start_flag", {31'd0, p_bwf},        32'd1);
        checkOutput("par_busy",       {31'd0, p_busy},       32'd1);
        checkOutput("par_pop_level",  {29'd0, p_fifo_level}, 32'd0);
        checkOutput("par_in_ready",   {31'd0, p_in_ready},   32'd1);
        p_brd = 1'b1;
        tick();
        checkOutput("par_ack_delay1", {16'd0, p_out_data}, 32'h5678);
        tick();
        checkOutput("par_ack_delay2", {16'd0, p_out_data}, 32'h5678);
        tick();
        checkOutput("par_lane1",      {16'd0, p_out_data}, 32'h1234);
        checkOutput("par_lane1_flag", {31'd0, p_bwf},      32'd0);
        p_brd = 1'b0;
        repeat (2) tick();
        checkOutput("par_word_flag_early", {31'd0, p_wwf}, 32'd0);
        tick();
        checkOutput("par_word_flag_rise", {31'd0, p_wwf}, 32'd1);
        p_wrd = 1'b1;
        repeat (2) tick();
        checkOutput("par_word_flag_hold", {31'd0, p_wwf},        32'd1);
        checkOutput("par_sent_early",     {16'd0, p_words_sent}, 32'd0);
        tick();
        checkOutput("par_word_flag_fall", {31'd0, p_wwf},        32'd0);
        checkOutput("par_sent",           {16'd0, p_words_sent}, 32'd1);
        checkOutput("par_idle",           {31'd0, p_busy},       32'd0);
        p_wrd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
